// File: rtl/trim_deadband.sv
// Purpose : two-channel complementary gate-drive generator with a dead band
//           between the high-side (p) and low-side (n) drive of each channel.
// Latency : n falls one edge after in=1 is sampled, p rises DeadTime edges
//           later; p falls one edge after in=0 is sampled, n rises DeadTime
//           edges later.
// Backpressure: none. The outputs follow the inputs every cycle.
//
// Ports:
//   clock               single clock domain
//   reset               synchronous, active-high; forces both channels to the
//                       dead state and clears the kill latch
//   en                  hardware enable; low holds both channels dead
//   kill                fault kill request (used only with TRIM_DEADBAND_KILL_EN)
//   pwm1, pwm2          raw PWM inputs, already registered upstream in this domain
//   pwm1_p / pwm1_n     channel-1 high-side / low-side drive
//   pwm2_p / pwm2_n     channel-2 high-side / low-side drive
//   killed              kill latch status (constant 0 without the kill feature)
//
// Build option: define TRIM_DEADBAND_KILL_EN to build the kill latch.
// Without it the kill input is ignored and killed reads 0.

module trim_deadband #(
  parameter logic [7:0] DeadTime = 8'd4  // dead-band length in cycles, 1..255
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic kill,
  input  logic pwm1,
  input  logic pwm2,
  output logic pwm1_p,
  output logic pwm1_n,
  output logic pwm2_p,
  output logic pwm2_n,
  output logic killed
);

  // LOW: n driven. DR: dead band on the rising side.
  // HIGH: p driven. DF: dead band on the falling side.
  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_DR   = 2'd1,
    ST_HIGH = 2'd2,
    ST_DF   = 2'd3
  } state_e;

  // The counter starts at 0 on entry to a dead state. It reaches this value
  // on the DeadTime-th cycle in that state, so the exit happens exactly
  // DeadTime edges after entry.
  localparam logic [7:0] CntLast = DeadTime - 8'd1;

  // When hold is high, both channels are parked in DF with a cleared counter.
  // When hold drops, each channel has to wait out a full dead band before
  // it asserts any drive.
  logic hold;

`ifdef TRIM_DEADBAND_KILL_EN
  logic killed_q;
  logic killed_d;

  // kill wins over the clear condition. If kill and en=0 arrive together,
  // the latch stays set.
  always_comb begin
    killed_d = killed_q;
    if (kill) begin
      killed_d = 1'b1;
    end else if (!en) begin
      killed_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      killed_q <= 1'b0;
    end else begin
      killed_q <= killed_d;
    end
  end

  // The kill input holds the channels directly. This makes the drives go
  // off on the same edge that sets the latch, not one cycle later.
  assign hold   = !en || kill || killed_q;
  assign killed = killed_q;
`else
  logic unused_kill;
  assign unused_kill = kill;
  assign hold        = !en;
  assign killed      = 1'b0;
`endif

  logic [1:0] pwm_in;
  logic [1:0] drv_p;
  logic [1:0] drv_n;

  assign pwm_in = {pwm2, pwm1};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_e     state_q;
    state_e     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       p_q;
    logic       n_q;
    logic       in_w;

    assign in_w = pwm_in[ch];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (hold) begin
        state_d = ST_DF;
        cnt_d   = 8'd0;
      end else begin
        case (state_q)
          ST_LOW: begin
            if (in_w) begin
              state_d = ST_DR;
              cnt_d   = 8'd0;
            end
          end
          ST_DR: begin
            // If the input drops during the rising dead band, the channel
            // turns straight into a falling dead band. This gives a glitch
            // a dead period only and never a p pulse.
            if (!in_w) begin
              state_d = ST_DF;
              cnt_d   = 8'd0;
            end else if (cnt_q == CntLast) begin
              state_d = ST_HIGH;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          ST_HIGH: begin
            if (!in_w) begin
              state_d = ST_DF;
              cnt_d   = 8'd0;
            end
          end
          ST_DF: begin
            if (in_w) begin
              state_d = ST_DR;
              cnt_d   = 8'd0;
            end else if (cnt_q == CntLast) begin
              state_d = ST_LOW;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
          default: begin
            state_d = ST_DF;
            cnt_d   = 8'd0;
          end
        endcase
      end
    end

    // The drive flops are decoded from the next state. They change together
    // with state_q, so the pins come straight from flops. They can never
    // both be 1, because ST_HIGH and ST_LOW are distinct states.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q <= ST_DF;
        cnt_q   <= 8'd0;
        p_q     <= 1'b0;
        n_q     <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        p_q     <= (state_d == ST_HIGH);
        n_q     <= (state_d == ST_LOW);
      end
    end

    assign drv_p[ch] = p_q;
    assign drv_n[ch] = n_q;
  end

  assign pwm1_p = drv_p[0];
  assign pwm1_n = drv_n[0];
  assign pwm2_p = drv_p[1];
  assign pwm2_n = drv_n[1];

endmodule

// File: tb/tb_trim_deadband.sv
// Purpose : testbench for trim_deadband. The main instance uses DeadTime=4.
//           Two more instances use DeadTime=1 and DeadTime=255 and share
//           the same stimulus for the invariant monitor.
// Latency : n/a
// Backpressure: n/a

module tb_trim_deadband;

  logic clock = 1'b0;
  logic reset;
  logic en;
  logic kill;
  logic pwm1;
  logic pwm2;

  // Index 0: DeadTime=4, index 1: DeadTime=1, index 2: DeadTime=255
  wire [2:0] p1;
  wire [2:0] n1;
  wire [2:0] p2;
  wire [2:0] n2;
  wire [2:0] kd;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  trim_deadband #(.DeadTime(8'd4)) dut (
    .clock(clock), .reset(reset), .en(en), .kill(kill), .pwm1(pwm1), .pwm2(pwm2),
    .pwm1_p(p1[0]), .pwm1_n(n1[0]), .pwm2_p(p2[0]), .pwm2_n(n2[0]), .killed(kd[0])
  );

  trim_deadband #(.DeadTime(8'd1)) dut_dt1 (
    .clock(clock), .reset(reset), .en(en), .kill(kill), .pwm1(pwm1), .pwm2(pwm2),
    .pwm1_p(p1[1]), .pwm1_n(n1[1]), .pwm2_p(p2[1]), .pwm2_n(n2[1]), .killed(kd[1])
  );

  trim_deadband #(.DeadTime(8'd255)) dut_dt255 (
    .clock(clock), .reset(reset), .en(en), .kill(kill), .pwm1(pwm1), .pwm2(pwm2),
    .pwm1_p(p1[2]), .pwm1_n(n1[2]), .pwm2_p(p2[2]), .pwm2_n(n2[2]), .killed(kd[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 ns after the active edge, and outputs are read at
  // that same point.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Invariant monitor for all six channels. Each channel index c maps to
  // instance c%3; c<3 is channel 1, c>=3 is channel 2.
  int dt_tab [3] = '{4, 1, 255};
  int run_c [6];
  int rises [6];
  logic prev_p [6];
  int overlap_err = 0;
  int dead_err = 0;
  logic mon_on = 1'b0;
  logic pp;
  logic nn;

  always @(negedge clock) begin
    if (mon_on) begin
      for (int c = 0; c < 6; c++) begin
        pp = (c < 3) ? p1[c % 3] : p2[c % 3];
        nn = (c < 3) ? n1[c % 3] : n2[c % 3];
        if (pp === 1'b1 && nn === 1'b1) overlap_err++;
        if (pp === 1'b1 && prev_p[c] !== 1'b1) begin
          rises[c]++;
          if (run_c[c] < dt_tab[c % 3]) dead_err++;
        end
        if (pp === 1'b0 && nn === 1'b0) run_c[c]++;
        else run_c[c] = 0;
        prev_p[c] = pp;
      end
    end
  end

  logic [15:0] pat_p;
  logic [15:0] pat_n;

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    kill  = 1'b0;
    pwm1  = 1'b0;
    pwm2  = 1'b0;

    // Reset for two cycles
    step();
    mon_on = 1'b1;
    step();
    chk("rst_p1", p1[0], 0);
    chk("rst_n1", n1[0], 0);
    chk("rst_p2", p2[0], 0);
    chk("rst_n2", n2[0], 0);
    chk("rst_killed", kd[0], 0);

    // Enable with idle inputs: 4 dead cycles, then n asserts
    reset = 1'b0;
    en    = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("en_wait_n1", n1[0], 0);
      chk("en_wait_p1", p1[0], 0);
    end
    step();
    chk("en_done_n1", n1[0], 1);
    chk("en_done_n2", n2[0], 1);

    // Normal pulse: pwm1 high for 10 cycles. k is the edge index from t0.
    // p is 1 for k=4..9. n is 0 for k=0..13 and 1 from k=14.
    pat_p = 16'h03F0;
    pat_n = 16'hC000;
    pwm1 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      pwm1 = (k + 1 <= 9);
      chk("pulse_p1", p1[0], pat_p[k]);
      chk("pulse_n1", n1[0], pat_n[k]);
    end
    chk("pulse_n2_steady", n2[0], 1);

    // Short pulse: pwm2 high for 3 cycles. n2 is low for k=0..6 and p2 never rises.
    pat_n = 16'h0180;
    pwm2 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      pwm2 = (k + 1 <= 2);
      chk("short_p2", p2[0], 0);
      chk("short_n2", n2[0], pat_n[k]);
      chk("short_n1_unaffected", n1[0], 1);
    end

    // Drop enable during HIGH, then re-enable with pwm1 still high
    pwm1 = 1'b1;
    repeat (5) step();
    chk("pre_en_p1", p1[0], 1);
    en = 1'b0;
    step();
    chk("en_off_p1", p1[0], 0);
    chk("en_off_n1", n1[0], 0);
    chk("en_off_n2", n2[0], 0);
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("reen_p1_dead", p1[0], 0);
      chk("reen_n1_dead", n1[0], 0);
    end
    step();
    chk("reen_p1_high", p1[0], 1);

`ifdef TRIM_DEADBAND_KILL_EN
    // One-cycle kill pulse during HIGH
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_p1", p1[0], 0);
    chk("kill_n1", n1[0], 0);
    chk("kill_p2", p2[0], 0);
    chk("kill_n2", n2[0], 0);
    chk("kill_latched", kd[0], 1);
    repeat (3) step();
    chk("kill_held", kd[0], 1);
    chk("kill_held_p1", p1[0], 0);
    en = 1'b0;
    step();
    chk("kill_cleared", kd[0], 0);
    en   = 1'b1;
    pwm1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("kill_rec_n1_dead", n1[0], 0);
    end
    step();
    chk("kill_rec_n1", n1[0], 1);
`else
    // Without the kill feature the kill input has no effect
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_ignored_p1", p1[0], 1);
    chk("kill_ignored_killed", kd[0], 0);
    pwm1 = 1'b0;
    repeat (5) step();
    chk("kill_ignored_n1", n1[0], 1);
`endif

    // Reset during HIGH clears the outputs on the next edge and drops the count
    pwm1 = 1'b1;
    repeat (5) step();
    chk("pre_rst_p1", p1[0], 1);
    reset = 1'b1;
    step();
    chk("midrst_p1", p1[0], 0);
    chk("midrst_n1", n1[0], 0);
    chk("midrst_p2", p2[0], 0);
    chk("midrst_n2", n2[0], 0);
    chk("midrst_killed", kd[0], 0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("postrst_p1_dead", p1[0], 0);
    end
    step();
    chk("postrst_p1_high", p1[0], 1);

    // Random stress: a fast-toggle phase, then a slow-toggle phase long
    // enough for the DeadTime=255 instance to assert p
    for (int i = 0; i < 10000; i++) begin
      int unsigned lim;
      lim = (i < 4000) ? 3 : 400;
      if ($urandom_range(0, lim - 1) == 0) pwm1 = ~pwm1;
      if ($urandom_range(0, lim - 1) == 0) pwm2 = ~pwm2;
      if ($urandom_range(0, 511) == 0) en = ~en;
      kill = ($urandom_range(0, 999) == 0);
      step();
    end
    kill = 1'b0;
    step();

    chk("stress_overlap", overlap_err, 0);
    chk("stress_deadband", dead_err, 0);
    chk("stress_dt1_pulses_seen", ((rises[1] + rises[4]) > 0) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
